video_timing_meter: RTL and testbench
=====================================

VIDEO_TIMING_METER -- requirements
Module: video_timing_meter

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  system/video clock
- reset  in  1  asynchronous, active-high
- ce_pix  in  1  pixel enable; all sampling occurs only on clk edges with ce_pix=1
- hsync  in  1  horizontal sync, either polarity
- vsync  in  1  vertical sync, either polarity
- hblank  in  1  horizontal blank, active-high
- vblank  in  1  vertical blank, active-high
- htotal  out  12  pixels per line
- hactive  out  12  non-blank pixels per line
- vtotal  out  12  lines per frame
- vactive  out  12  non-blank lines per frame
- hs_pol  out  1  1 = hsync active-high
- vs_pol  out  1  1 = vsync active-high
- valid  out  1  published values are locked
- changed  out  1  one-clk pulse when published values update to new contents
REQ-002 SHALL have parameter TIMEOUT, default 22, meaning the watchdog width in clk cycles (2^TIMEOUT).

Function
REQ-003 Line start SHALL be a ce_pix sample with hblank=0 where the previous ce_pix sample had hblank=1.
REQ-004 Frame start SHALL be a line start with vblank=0 where the previous line start had vblank=1.
REQ-005 The pixel counter SHALL count ce_pix samples since the last line start, inclusive of the line-start sample; at each line start it SHALL latch the completed count as the line total.
REQ-006 The active-pixel counter SHALL count ce_pix samples with hblank=0 and SHALL be latched at each line start.
REQ-007 The hsync-high counter SHALL count ce_pix samples with hsync=1 per line; the line polarity SHALL be 1 when 2*high_count < line_total.
REQ-008 The line counter SHALL count line starts since the last frame start, inclusive of it; at each frame start it SHALL latch vtotal_m, plus vactive_m as the count of line starts with vblank=0.
REQ-009 vs_pol_m SHALL be 1 when 2*(line starts with vsync=1) < vtotal_m.
REQ-010 All counters SHALL saturate at 4095 and SHALL never wrap.
REQ-011 Measurement set M = {htotal_m, hactive_m, vtotal_m, vactive_m, hs_pol_m, vs_pol_m}, where the h fields are taken from the last line of the frame.
REQ-012 The FSM SHALL have states IDLE, MEASURE and LOCKED:
- IDLE: first frame start -> MEASURE; stored candidate not yet valid.
- MEASURE: at each frame start, compare M with the candidate. If equal, match_cnt+1; otherwise store M as the candidate and set match_cnt=0. When match_cnt reaches 2, publish the candidate and go to LOCKED.
- LOCKED: frame start with M equal to the published set -> stay; otherwise valid=0, candidate=M, match_cnt=0, go to MEASURE.
REQ-013 valid SHALL be 1 exactly when in LOCKED, asserted in the same clk cycle that the outputs are published.
REQ-014 changed SHALL pulse for 1 clk on publish only when the published set differs from the previously published set; the first publish after reset SHALL always pulse.
REQ-015 The watchdog SHALL count clk cycles and clear on every frame start; at 2^TIMEOUT-1 it SHALL force IDLE and valid=0 while published values are held.
REQ-016 A simultaneous frame start and watchdog expiry SHALL give priority to the frame start.
REQ-017 Totals alternating frame-to-frame (e.g. interlace) SHALL never reach LOCKED.
REQ-018 ce_pix=0 cycles SHALL not advance any counter except the watchdog.

Reset
REQ-019 Asserting reset SHALL immediately set all outputs to 0, all counters to 0, match_cnt to 0, the FSM to IDLE and the previous-sample flags to 1.
REQ-020 Asserting reset mid-frame SHALL discard the partial measurement; the first frame start after release is treated as the first frame.

Verification
REQ-021 ce_pix every clk, 800x525 with 640x480 active, hsync/vsync active-low -> valid=1 at the 4th frame start: htotal=800, hactive=640, vtotal=525, vactive=480, hs_pol=0, vs_pol=0, changed pulses once.
REQ-022 Same timing with ce_pix every 4th clk and active-high syncs -> identical totals, hs_pol=1, vs_pol=1.
REQ-023 While locked, switch to 858x262 -> valid=0 at the next frame start, then valid=1 with the new values 2 frames later, and changed pulses.
REQ-024 Alternate vtotal 262/263 -> valid stays 0 indefinitely.
REQ-025 Stop ce_pix while locked -> valid=0 after 2^TIMEOUT clk, published values unchanged.
REQ-026 Assert reset mid-frame, then resume -> outputs 0 during reset; after release, lock at the 4th frame start, and changed pulses even for identical timing.

Source files
------------

// File: rtl/video_timing_meter.sv
// video_timing_meter
//   Measures the raster timing of an incoming video stream and publishes it
//   once three consecutive complete frames have agreed on the same values.
//   A frame whose measurements disagree with the published set drops the lock
//   and starts a new measurement run.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   ce_pix            pixel enable; everything except the watchdog advances
//                     only on clk edges with ce_pix=1
//   hsync, vsync      syncs of either polarity
//   hblank, vblank    active-high blanking
//   htotal, hactive   pixels per line / non-blank pixels per line
//   vtotal, vactive   lines per frame / non-blank lines per frame
//   hs_pol, vs_pol    1 = sync is active-high
//   valid             published values are locked
//   changed           one-clk pulse when a publish brings new contents
module video_timing_meter #(
    parameter int TIMEOUT = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblank,
    input  logic        vblank,
    output logic [11:0] htotal,
    output logic [11:0] hactive,
    output logic [11:0] vtotal,
    output logic [11:0] vactive,
    output logic        hs_pol,
    output logic        vs_pol,
    output logic        valid,
    output logic        changed
);

    typedef struct packed {
        logic [11:0] ht;
        logic [11:0] ha;
        logic [11:0] vt;
        logic [11:0] va;
        logic        hp;
        logic        vp;
    } meas_t;

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (&v) ? v : v + 12'd1;
    endfunction

    logic               prev_hblank;   // hblank at the previous ce_pix sample
    logic               prev_vblank;   // vblank at the previous line start
    logic [11:0]        pix_cnt, act_cnt, hs_cnt;
    logic [11:0]        line_cnt, vact_cnt, vs_cnt;
    logic               line_start, frame_start;
    meas_t              meas, cand, pub;
    logic               cand_ok, ever_pub;
    logic [1:0]         match_cnt;
    logic [TIMEOUT-1:0] wd;
    state_t             state;

    assign line_start  = ce_pix & ~hblank & prev_hblank;
    assign frame_start = line_start & ~vblank & prev_vblank;

    // At a frame start the horizontal counters still hold the line that just
    // completed, which is the last line of the frame being closed, so the
    // measurement set can be taken straight from the live counters.
    assign meas = {pix_cnt, act_cnt, line_cnt, vact_cnt,
                   ({hs_cnt, 1'b0} < {1'b0, pix_cnt}),
                   ({vs_cnt, 1'b0} < {1'b0, line_cnt})};
    assign pub  = {htotal, hactive, vtotal, vactive, hs_pol, vs_pol};

    // Line / frame counters; the line-start sample itself counts as 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_hblank <= 1'b1;
            prev_vblank <= 1'b1;
            pix_cnt     <= '0;
            act_cnt     <= '0;
            hs_cnt      <= '0;
            line_cnt    <= '0;
            vact_cnt    <= '0;
            vs_cnt      <= '0;
        end else if (ce_pix) begin
            prev_hblank <= hblank;
            if (line_start) begin
                prev_vblank <= vblank;
                pix_cnt     <= 12'd1;
                act_cnt     <= 12'd1;
                hs_cnt      <= {11'd0, hsync};
                if (frame_start) begin
                    line_cnt <= 12'd1;
                    vact_cnt <= 12'd1;
                    vs_cnt   <= {11'd0, vsync};
                end else begin
                    line_cnt <= sat_inc(line_cnt);
                    if (!vblank) vact_cnt <= sat_inc(vact_cnt);
                    if (vsync)   vs_cnt   <= sat_inc(vs_cnt);
                end
            end else begin
                pix_cnt <= sat_inc(pix_cnt);
                if (!hblank) act_cnt <= sat_inc(act_cnt);
                if (hsync)   hs_cnt  <= sat_inc(hs_cnt);
            end
        end
    end

    // Lock FSM with watchdog; a frame start wins over a simultaneous expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            cand_ok   <= 1'b0;
            match_cnt <= '0;
            ever_pub  <= 1'b0;
            wd        <= '0;
            htotal    <= '0;
            hactive   <= '0;
            vtotal    <= '0;
            vactive   <= '0;
            hs_pol    <= 1'b0;
            vs_pol    <= 1'b0;
            valid     <= 1'b0;
            changed   <= 1'b0;
        end else begin
            changed <= 1'b0;
            wd      <= frame_start ? '0 : wd + 1'b1;
            if (frame_start) begin
                case (state)
                    // The first frame after reset/timeout is partial; discard it.
                    IDLE: begin
                        state     <= MEASURE;
                        cand_ok   <= 1'b0;
                        match_cnt <= '0;
                    end
                    MEASURE: begin
                        if (cand_ok && meas == cand) begin
                            match_cnt <= match_cnt + 2'd1;
                            if (match_cnt == 2'd1) begin
                                {htotal, hactive, vtotal, vactive, hs_pol, vs_pol} <= cand;
                                valid    <= 1'b1;
                                changed  <= !ever_pub || (cand != pub);
                                ever_pub <= 1'b1;
                                state    <= LOCKED;
                            end
                        end else begin
                            cand      <= meas;
                            cand_ok   <= 1'b1;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (meas != pub) begin
                            valid     <= 1'b0;
                            cand      <= meas;
                            cand_ok   <= 1'b1;
                            match_cnt <= '0;
                            state     <= MEASURE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (&wd) begin
                // Published values are deliberately left in place.
                state     <= IDLE;
                valid     <= 1'b0;
                cand_ok   <= 1'b0;
                match_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_meter.sv
// tb_video_timing_meter
//   Generates whole frames from a small table of raster formats and keeps a
//   frame-level reference: the lock rule is "the last three complete frames
//   measured since reset/timeout are identical". Expected results are queued
//   at every frame start and checked by an independent monitor.
module tb_video_timing_meter;

    localparam int TO     = 13;
    localparam int WD_CYC = 1 << TO;

    logic        clk = 1'b0;
    logic        reset, ce_pix, hsync, vsync, hblank, vblank;
    logic [11:0] htotal, hactive, vtotal, vactive;
    logic        hs_pol, vs_pol, valid, changed;

    video_timing_meter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .htotal(htotal), .hactive(hactive), .vtotal(vtotal), .vactive(vactive),
        .hs_pol(hs_pol), .vs_pol(vs_pol), .valid(valid), .changed(changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ht, ha, vt, va, hsw, vsw, hpol, vpol, div;
    } fp_t;

    typedef struct packed {
        logic [11:0] ht, ha, vt, va;
        logic        hp, vp;
    } m_t;

    typedef struct packed {
        logic valid, changed;
        m_t   pub;
    } exp_t;

    int   n_chk = 0, n_fail = 0;
    exp_t sb[$];
    logic fs_mark = 1'b0;

    // reference state
    int   wcount;
    m_t   hist[$];
    m_t   m_pub;
    bit   m_valid, m_ever;
    fp_t  prev_p;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic m_t meas_of(input fp_t p);
        m_t m;
        int hi, vi;
        hi = p.hpol ? p.hsw : p.ht - p.hsw;
        vi = p.vpol ? p.vsw : p.vt - p.vsw;
        m.ht = 12'(p.ht);
        m.ha = 12'(p.ha);
        m.vt = 12'(p.vt);
        m.va = 12'(p.va);
        m.hp = (2 * hi < p.ht);
        m.vp = (2 * vi < p.vt);
        return m;
    endfunction

    task automatic model_restart(input bit full);
        wcount  = 0;
        hist.delete();
        m_valid = 0;
        if (full) begin
            m_ever = 0;
            m_pub  = '0;
        end
    endtask

    task automatic model_frame_start();
        exp_t e;
        m_t   m;
        bit   v;
        wcount++;
        m = '0;
        if (wcount >= 2) begin
            m = meas_of(prev_p);
            hist.push_back(m);
            if (hist.size() > 3) void'(hist.pop_front());
        end
        v = (hist.size() == 3) && (hist[0] == hist[1]) && (hist[1] == hist[2]);
        e.changed = 1'b0;
        if (v && !m_valid) begin
            e.changed = !m_ever || (m != m_pub);
            m_pub  = m;
            m_ever = 1;
        end
        m_valid = v;
        e.valid = v;
        e.pub   = m_pub;
        sb.push_back(e);
    endtask

    task automatic chk_zero();
        chk("rst_valid", valid, 0);   chk("rst_changed", changed, 0);
        chk("rst_htotal", htotal, 0); chk("rst_hactive", hactive, 0);
        chk("rst_vtotal", vtotal, 0); chk("rst_vactive", vactive, 0);
        chk("rst_hs_pol", hs_pol, 0); chk("rst_vs_pol", vs_pol, 0);
    endtask

    task automatic wd_test();
        @(negedge clk);
        ce_pix = 0; fs_mark = 0;
        chk("wd_valid_before", valid, m_valid);
        repeat (7000) @(negedge clk);
        chk("wd_valid_held", valid, m_valid);
        repeat (WD_CYC - 7000 + 4) @(negedge clk);
        chk("wd_valid_dropped", valid, 0);
        chk("wd_htotal", htotal, m_pub.ht);  chk("wd_hactive", hactive, m_pub.ha);
        chk("wd_vtotal", vtotal, m_pub.vt);  chk("wd_vactive", vactive, m_pub.va);
        chk("wd_hs_pol", hs_pol, m_pub.hp);  chk("wd_vs_pol", vs_pol, m_pub.vp);
        model_restart(0);
    endtask

    // One frame; optional mid-frame reset assert/release or ce_pix stall.
    task automatic run_frame(input fp_t p, input int rst_line, input int rel_line,
                             input int stop_line);
        for (int l = 0; l < p.vt; l++) begin
            if (l == stop_line) wd_test();
            if (l == rst_line) begin
                @(negedge clk);
                reset = 1; ce_pix = 0; fs_mark = 0;
                #1 chk_zero();
                model_restart(1);
            end
            if (l == rel_line) begin
                @(negedge clk);
                reset = 0; ce_pix = 0; fs_mark = 0;
            end
            for (int x = 0; x < p.ht; x++) begin
                @(negedge clk);
                hblank  = (x >= p.ha);
                hsync   = (x >= p.ha + 2 && x < p.ha + 2 + p.hsw) ? 1'(p.hpol) : !1'(p.hpol);
                vblank  = (l >= p.va);
                vsync   = (l > p.va && l <= p.va + p.vsw) ? 1'(p.vpol) : !1'(p.vpol);
                ce_pix  = 1;
                fs_mark = (l == 0 && x == 0 && !reset);
                if (fs_mark) model_frame_start();
                for (int d = 1; d < p.div; d++) begin
                    @(negedge clk);
                    ce_pix = 0; fs_mark = 0;
                end
            end
        end
        prev_p = p;
    endtask

    // Monitor: check the queued expectation right after each frame-start edge;
    // between frame starts changed must stay low.
    initial begin
        forever begin
            logic fs;
            exp_t e;
            @(posedge clk);
            fs = fs_mark;
            #1;
            if (fs) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("valid", valid, e.valid);
                    chk("changed", changed, e.changed);
                    chk("htotal", htotal, e.pub.ht);
                    chk("hactive", hactive, e.pub.ha);
                    chk("vtotal", vtotal, e.pub.vt);
                    chk("vactive", vactive, e.pub.va);
                    chk("hs_pol", hs_pol, e.pub.hp);
                    chk("vs_pol", vs_pol, e.pub.vp);
                end
            end else if (!reset) begin
                chk("changed_idle", changed, 0);
            end
        end
    end

    initial begin
        fp_t A, B, C, Ah, I0, I1, p;
        fp_t tbl[3];
        int  idx;
        A  = '{ht:40, ha:32, vt:25, va:20, hsw:4, vsw:2, hpol:0, vpol:0, div:1};
        B  = '{ht:54, ha:44, vt:17, va:12, hsw:5, vsw:2, hpol:0, vpol:0, div:1};
        C  = '{ht:48, ha:36, vt:20, va:15, hsw:6, vsw:2, hpol:1, vpol:0, div:1};
        Ah = A; Ah.hpol = 1; Ah.vpol = 1; Ah.div = 4;
        I0 = A; I1 = A; I1.vt = 26;
        tbl[0] = A; tbl[1] = B; tbl[2] = C;
        prev_p = A;
        model_restart(1);

        reset = 1; ce_pix = 0; hsync = 1; vsync = 1; hblank = 1; vblank = 1;
        repeat (3) @(negedge clk);
        #1 chk_zero();
        @(negedge clk) reset = 0;

        // 640x480-style lock with active-low syncs
        repeat (6) run_frame(A, -1, -1, -1);
        // format switch while locked
        repeat (4) run_frame(B, -1, -1, -1);
        // random format runs
        idx = 0; p = A;
        repeat (10) begin
            if ($urandom_range(0, 9) < 4) begin
                idx = $urandom_range(0, 2);
                p = tbl[idx];
                p.hpol = $urandom_range(0, 1);
                p.vpol = $urandom_range(0, 1);
            end
            run_frame(p, -1, -1, -1);
        end
        // slow pixel clock, active-high syncs
        repeat (5) run_frame(Ah, -1, -1, -1);
        // alternating frame heights never lock
        repeat (4) begin
            run_frame(I0, -1, -1, -1);
            run_frame(I1, -1, -1, -1);
        end
        // lock, stall ce_pix into a timeout, then recover
        repeat (5) run_frame(A, -1, -1, -1);
        run_frame(A, -1, -1, 5);
        repeat (5) run_frame(A, -1, -1, -1);
        // reset mid-frame, release in vertical blanking
        run_frame(A, 3, 22, -1);
        repeat (5) run_frame(A, -1, -1, -1);

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
